// File: rtl/mul_share_arb_if.sv
// mul_share_arb_if
// Bundles the requester side and the shared-multiplier side of mul_share_arb.
//   req_valid/req_ready   per-requester handshake (req_ready is one-hot)
//   req_a/req_b           packed signed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid             one-hot response pulse
//   rsp_result/rsp_err    product and timeout flag, valid with rsp_valid
//   mul_start/mul_a/mul_b start pulse and held operands to the multiplier
//   mul_result/mul_done   product and one-cycle done pulse from the multiplier
//   mul_busy              multiplier busy
// Modport slave is the arbiter's view. Modport master is the view of the
// surrounding requesters and multiplier.
interface mul_share_arb_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       rsp_valid;
    logic [2*WIDTH-1:0]    rsp_result;
    logic                  rsp_err;
    logic                  mul_start;
    logic [WIDTH-1:0]      mul_a;
    logic [WIDTH-1:0]      mul_b;
    logic [2*WIDTH-1:0]    mul_result;
    logic                  mul_done;
    logic                  mul_busy;

    modport slave (
        input  req_valid, req_a, req_b, mul_result, mul_done, mul_busy,
        output req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, mul_result, mul_done, mul_busy,
        input  req_ready, rsp_valid, rsp_result, rsp_err, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_arb.sv
// mul_share_arb
// Round-robin arbiter and sequencer that shares one iterative signed
// multiplier among NREQ requesters, with a watchdog on the multiplier's done.
//   clk    clock
//   rst_n  asynchronous active-low reset (shared with the multiplier)
//   bus    mul_share_arb_if.slave: requester handshake/operands, one-hot
//          responses, and the start/operand/done/busy multiplier link
//
// state  | meaning
// IDLE   | arbitrate; grant one requester when the multiplier is not busy
// START  | mul_start high for one cycle, watchdog cleared
// WAIT   | wait for mul_done, or give up after TIMEOUT cycles
// RESP   | one-hot rsp_valid pulse to the granted requester
module mul_share_arb #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_share_arb_if.slave   bus
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [GW-1:0]        gnt_id_q, gnt_id_d;
    logic [WIDTH-1:0]     op_a_q, op_a_d;
    logic [WIDTH-1:0]     op_b_q, op_b_d;
    logic [CW-1:0]        wait_cnt_q, wait_cnt_d;
    logic [2*WIDTH-1:0]   rsp_result_q, rsp_result_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
    logic                 mul_start_q, mul_start_d;
    logic [NREQ-1:0]      req_ready;

    logic                 grant_found;
    logic [GW-1:0]        grant_idx;
    logic [GW-1:0]        scan_idx;

    // Rotating-priority search starting just after the last served requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = GW'((int'(last_grant_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        wait_cnt_d   = wait_cnt_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = '0;
        mul_start_d  = 1'b0;
        req_ready    = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found && !bus.mul_busy) begin
                    req_ready[grant_idx] = 1'b1;
                    op_a_d      = bus.req_a[grant_idx*WIDTH +: WIDTH];
                    op_b_d      = bus.req_b[grant_idx*WIDTH +: WIDTH];
                    gnt_id_d    = grant_idx;
                    mul_start_d = 1'b1;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // done is checked first so it wins over a coincident timeout
                if (bus.mul_done) begin
                    rsp_result_d          = bus.mul_result;
                    rsp_err_d             = 1'b0;
                    rsp_valid_d[gnt_id_q] = 1'b1;
                    state_d               = ST_RESP;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    rsp_result_d          = '0;
                    rsp_err_d             = 1'b1;
                    rsp_valid_d[gnt_id_q] = 1'b1;
                    state_d               = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                last_grant_d = gnt_id_q;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GW'(NREQ - 1);
            gnt_id_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            wait_cnt_q   <= '0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= '0;
            mul_start_q  <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            wait_cnt_q   <= wait_cnt_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            mul_start_q  <= mul_start_d;
        end
    end

    // Operands are driven from the grant-time copy in every state: the
    // multiplier derives its result sign from these live inputs.
    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_err    = rsp_err_q;
    assign bus.mul_start  = mul_start_q;
    assign bus.mul_a      = op_a_q;
    assign bus.mul_b      = op_b_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// tb_mul_share_arb
// Directed bench for mul_share_arb with a small behavioural multiplier
// (fixed latency, can be disabled to exercise the watchdog).
module tb_mul_share_arb;
    localparam int WIDTH   = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    mul_share_arb_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    mul_share_arb #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic        mdl_en     = 1'b1;
    logic        busy_force = 1'b0;
    logic        late_done  = 1'b0;
    logic        mdl_done   = 1'b0;
    logic        mdl_busy   = 1'b0;
    logic [31:0] mdl_result = '0;
    int          mdl_cnt    = 0;

    assign bus.mul_done   = mdl_done | late_done;
    assign bus.mul_result = late_done ? 32'h0000_1234 : mdl_result;
    assign bus.mul_busy   = mdl_busy | busy_force;

    function automatic logic [31:0] smul(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] ea;
        logic signed [31:0] eb;
        ea = {{16{a[15]}}, a};
        eb = {{16{b[15]}}, b};
        return ea * eb;
    endfunction

    // Multiplier model: product taken from the live operands at done time.
    always @(negedge clk) begin
        mdl_done = 1'b0;
        if (!rst_n) begin
            mdl_busy = 1'b0;
            mdl_cnt  = 0;
        end else if (mdl_busy) begin
            mdl_cnt--;
            if (mdl_cnt == 0) begin
                mdl_done   = 1'b1;
                mdl_busy   = 1'b0;
                mdl_result = smul(bus.mul_a, bus.mul_b);
            end
        end else if (bus.mul_start && mdl_en) begin
            mdl_busy = 1'b1;
            mdl_cnt  = LAT;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input int idx, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[idx*WIDTH +: WIDTH] = a;
        bus.req_b[idx*WIDTH +: WIDTH] = b;
    endtask

    task automatic wait_rsp(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.rsp_valid == 4'b0000 && n < 200);
        check({tag, "_rsp_seen"}, 64'(bus.rsp_valid != 4'b0000), 64'd1);
    endtask

    task automatic run_req(input string tag, input int idx, input logic [15:0] a,
                           input logic [15:0] b, input logic [31:0] exp_res);
        logic [3:0] oh;
        int n;
        oh = 4'b0001 << idx;
        set_ops(idx, a, b);
        bus.req_valid[idx] = 1'b1;
        #1;
        check({tag, "_ready"}, bus.req_ready, oh);
        tick();
        check({tag, "_start"}, bus.mul_start, 1'b1);
        check({tag, "_ready_off"}, bus.req_ready, 4'b0000);
        check({tag, "_mul_a"}, bus.mul_a, a);
        check({tag, "_mul_b"}, bus.mul_b, b);
        bus.req_valid = '0;
        tick();
        check({tag, "_start_pulse"}, bus.mul_start, 1'b0);
        wait_rsp(tag, n);
        check({tag, "_rsp_valid"}, bus.rsp_valid, oh);
        check({tag, "_result"}, bus.rsp_result, exp_res);
        check({tag, "_err"}, bus.rsp_err, 1'b0);
        tick();
        check({tag, "_rsp_pulse"}, bus.rsp_valid, 4'b0000);
        check({tag, "_result_hold"}, bus.rsp_result, exp_res);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no end expected end of run");
        $fatal(1, "global timeout");
    end

    logic [31:0] fair_res [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFA, 32'hFFFF_FFF4, 32'hFFFF_FFEC};

    initial begin
        int n;
        int unstable;
        int exp_id;

        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick();
        tick();
        check("rst_ready", bus.req_ready, 4'b0000);
        check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
        check("rst_result", bus.rsp_result, 32'h0);
        check("rst_err", bus.rsp_err, 1'b0);
        check("rst_start", bus.mul_start, 1'b0);
        check("rst_mul_a", bus.mul_a, 16'h0);
        check("rst_mul_b", bus.mul_b, 16'h0);
        rst_n = 1'b1;
        tick();

        // Single request and boundary operands.
        run_req("t1", 0, 16'hFFFD, 16'h0007, 32'hFFFF_FFEB);
        run_req("t2a", 2, 16'h8000, 16'h8000, 32'h4000_0000);
        run_req("t2b", 3, 16'h0000, 16'hFFFF, 32'h0000_0000);

        // Fairness: all requesters held valid, last grant was 3.
        for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1), 16'(-(i + 2)));
        bus.req_valid = 4'hF;
        for (int i = 0; i < 6; i++) begin
            exp_id = i % NREQ;
            #1;
            check($sformatf("fair%0d_ready", i), bus.req_ready, 4'b0001 << exp_id);
            tick();
            tick();
            wait_rsp($sformatf("fair%0d", i), n);
            check($sformatf("fair%0d_rsp_valid", i), bus.rsp_valid, 4'b0001 << exp_id);
            check($sformatf("fair%0d_result", i), bus.rsp_result, fair_res[exp_id]);
            tick();
        end
        bus.req_valid = '0;
        tick();

        // Watchdog: multiplier never answers. Last grant was 1.
        mdl_en = 1'b0;
        set_ops(1, 16'h0005, 16'h0005);
        bus.req_valid[1] = 1'b1;
        #1;
        check("wd_ready", bus.req_ready, 4'b0010);
        tick();
        check("wd_start", bus.mul_start, 1'b1);
        bus.req_valid = '0;
        wait_rsp("wd", n);
        check("wd_wait_cycles", 64'(n - 1), 64'(TIMEOUT));
        check("wd_rsp_valid", bus.rsp_valid, 4'b0010);
        check("wd_err", bus.rsp_err, 1'b1);
        check("wd_result", bus.rsp_result, 32'h0);
        tick();
        check("wd_idle_rsp", bus.rsp_valid, 4'b0000);
        late_done = 1'b1;
        tick();
        late_done = 1'b0;
        check("wd_late_rsp", bus.rsp_valid, 4'b0000);
        tick();
        check("wd_late_rsp2", bus.rsp_valid, 4'b0000);
        check("wd_late_err", bus.rsp_err, 1'b1);
        check("wd_late_result", bus.rsp_result, 32'h0);
        mdl_en = 1'b1;

        // Multiplier busy blocks the grant.
        busy_force = 1'b1;
        set_ops(1, 16'h0064, 16'hFFFB);
        bus.req_valid[1] = 1'b1;
        #1;
        check("busy_ready0", bus.req_ready, 4'b0000);
        tick();
        tick();
        check("busy_ready1", bus.req_ready, 4'b0000);
        check("busy_nostart", bus.mul_start, 1'b0);
        busy_force = 1'b0;
        #1;
        check("busy_ready_drop", bus.req_ready, 4'b0010);
        tick();
        bus.req_valid = '0;
        unstable = 0;
        n = 0;
        while (bus.rsp_valid == 4'b0000 && n < 200) begin
            if (bus.mul_a !== 16'h0064 || bus.mul_b !== 16'hFFFB) unstable++;
            tick();
            n++;
        end
        check("busy_rsp_valid", bus.rsp_valid, 4'b0010);
        check("busy_result", bus.rsp_result, 32'hFFFF_FE0C);
        check("busy_op_unstable", 64'(unstable), 64'd0);
        check("busy_mul_a_resp", bus.mul_a, 16'h0064);
        tick();
        check("busy_mul_a_idle", bus.mul_a, 16'h0064);
        check("busy_mul_b_idle", bus.mul_b, 16'hFFFB);

        // Reset in WAIT. Last grant was 1, so req2 is granted.
        set_ops(2, 16'h0003, 16'h0004);
        bus.req_valid[2] = 1'b1;
        #1;
        check("rw_ready", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        check("rw_mul_a_pre", bus.mul_a, 16'h0003);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_start", bus.mul_start, 1'b0);
        check("rw_rsp_valid", bus.rsp_valid, 4'b0000);
        check("rw_ready0", bus.req_ready, 4'b0000);
        check("rw_mul_a", bus.mul_a, 16'h0);
        check("rw_mul_b", bus.mul_b, 16'h0);
        check("rw_result", bus.rsp_result, 32'h0);
        check("rw_err", bus.rsp_err, 1'b0);
        tick();
        tick();
        check("rw_rsp_in_rst", bus.rsp_valid, 4'b0000);
        rst_n = 1'b1;
        bus.req_valid = 4'hF;
        #1;
        check("rw_first_grant", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = '0;
        check("rw_start2", bus.mul_start, 1'b1);
        wait_rsp("rw", n);
        check("rw_rsp_valid2", bus.rsp_valid, 4'b0001);
        check("rw_result2", bus.rsp_result, 32'hFFFF_FFFE);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mul_share_arb.md
Name: mul_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one iterative signed shift-add multiplier (16x16 -> 32, start/done/busy interface) among NREQ requesters.
- Accepts one operand pair at a time and pulses the multiplier start.
- Holds the operands stable for the whole operation, because the multiplier derives its result sign from its live operand inputs.
- Returns the product to the granted requester and guards against a missing done with a watchdog.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, maximum WAIT cycles before an error response

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_valid  input  NREQ  per-requester request valid
req_ready  output  NREQ  one-hot accept; combinational
req_a  input  NREQ*WIDTH  signed operand A; requester i at bits [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  signed operand B; same packing as req_a
rsp_valid  output  NREQ  one-hot response pulse; registered
rsp_result  output  2*WIDTH  signed product; valid with rsp_valid
rsp_err  output  1  timeout flag; valid with rsp_valid
mul_start  output  1  start pulse to the multiplier; registered
mul_a  output  WIDTH  operand A to the multiplier
mul_b  output  WIDTH  operand B to the multiplier
mul_result  input  2*WIDTH  multiplier product
mul_done  input  1  multiplier one-cycle done pulse
mul_busy  input  1  multiplier busy

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_result=0, rsp_err=0, mul_start=0, mul_a=0, mul_b=0, state=IDLE, last_grant=NREQ-1, wait counter=0.
- Arbitration:
  - Search order starts at (last_grant+1) mod NREQ and wraps around.
  - The first index with req_valid=1 wins.
- IDLE state:
  - A grant happens only when any req_valid=1 and mul_busy=0.
  - On grant, req_ready[g]=1 for exactly that cycle; the handshake is req_valid & req_ready.
  - Same edge: latch req_a/req_b slice g into op_a/op_b, latch g into gnt_id, go to START.
  - If mul_busy=1, no ready is asserted.
  - req_valid deasserting before a grant has no effect.
- START state: mul_start=1 for exactly one cycle, wait counter cleared, go to WAIT.
- WAIT state:
  - The counter increments each cycle.
  - mul_done=1: capture mul_result into rsp_result, rsp_err=0, go to RESP.
  - Counter reaches TIMEOUT-1 with no done: rsp_result=0, rsp_err=1, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP state: rsp_valid[gnt_id]=1 for one cycle, last_grant=gnt_id, go to IDLE.
- rsp_result and rsp_err hold their values until the next capture.
- Operand hold: mul_a/mul_b are driven from op_a/op_b in every state and change only on a new grant. This keeps the multiplier's combinational sign stable until done is captured.
- req_ready is 0 in START, WAIT and RESP, so at most one request is in flight.
- Throughput: the next grant is possible in the IDLE cycle after RESP. Per-request overhead is 3 cycles plus the multiplier latency.
- mul_done in IDLE, START or RESP is ignored.
- Reset mid-operation (any state): return to reset values; no response is issued and the in-flight request is dropped. The multiplier shares rst_n.
- Arithmetic: no width conversion; the product passes through unchanged as 2*WIDTH bits. The multiplier is expected to report done within WIDTH+4 cycles of mul_start.

Test Plan:
- Single request, req0 a=-3, b=7 -> req_ready[0] for 1 cycle; mul_start 1 cycle later; rsp_valid=0001, rsp_result=0xFFFFFFEB, rsp_err=0.
- Boundary operands a=-32768, b=-32768 on req2 -> rsp_valid=0100, rsp_result=0x40000000. Also a=0, b=-1 -> 0.
- Fairness: all four req_valid held high with distinct operands -> grant order 0,1,2,3,0,1. Each rsp_valid one-hot matches its grant; no requester is granted twice before the others.
- Watchdog: mul_done tied low -> exactly TIMEOUT WAIT cycles, then rsp_valid with rsp_err=1, rsp_result=0, and the arbiter returns to IDLE. A late mul_done afterwards is ignored.
- Resource busy: mul_busy=1 in IDLE with req1 valid -> req_ready stays 0. Drop mul_busy -> grant in the same cycle; mul_a/mul_b stable from grant through RESP.
- Reset in WAIT: assert rst_n=0 mid-multiply -> all outputs return to 0 asynchronously with no rsp_valid. After release, req0 is granted first (last_grant=NREQ-1).
